// File: rtl/clk_meter_pkg.sv
// Shared FSM state encoding for the clk_meter frequency/period meter.
package clk_meter_pkg;

   localparam logic [1:0] ST_IDLE_C    = 2'd0;
   localparam logic [1:0] ST_SYNC_C    = 2'd1;
   localparam logic [1:0] ST_MEASURE_C = 2'd2;
   localparam logic [1:0] ST_REPORT_C  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = ST_IDLE_C,
      ST_SYNC    = ST_SYNC_C,
      ST_MEASURE = ST_MEASURE_C,
      ST_REPORT  = ST_REPORT_C
   } state_e;

endpackage

// File: rtl/clk_meter_sync.sv
// Two-flop synchronizer plus history flop for the monitored clock; emits a
// one-cycle rise pulse. sync2_o exists only when CLK_METER_DUTY_EN is defined.
module clk_meter_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic mon_clk_i,
`ifdef CLK_METER_DUTY_EN
   output logic sync2_o,
`endif
   output logic rise_o
);

   logic [2:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], mon_clk_i};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) sync_q <= '0;
      else         sync_q <= sync_d;
   end

   assign rise_o = sync_q[1] & ~sync_q[2];
`ifdef CLK_METER_DUTY_EN
   assign sync2_o = sync_q[1];
`endif

endmodule

// File: rtl/clk_meter.sv
// Measures clk_i cycles spanned by 2**avg_log2_p periods of mon_clk_i, with
// SYNC/MEASURE timeouts. CLK_METER_DUTY_EN adds high_o (high-phase cycle count).
module clk_meter
   import clk_meter_pkg::*;
#(
   parameter int width_p    = 16,
   parameter int avg_log2_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               mon_clk_i,
   input  logic               start_i,
   output logic [width_p-1:0] count_o,
   output logic               stalled_o,
   output logic               v_o,
   input  logic               yumi_i
`ifdef CLK_METER_DUTY_EN
  ,output logic [width_p-1:0] high_o
`endif
);

   localparam int                 PW     = avg_log2_p + 1;
   localparam logic [width_p-1:0] MAX_C  = '1;
   localparam logic [PW-1:0]      LAST_C = PW'((1 << avg_log2_p) - 1);

   state_e             state_q, state_d;
   logic [width_p-1:0] cnt_q, cnt_d, to_q, to_d, count_q, count_d;
   logic [PW-1:0]      per_q, per_d;
   logic               stalled_q, stalled_d, v_q, v_d;
   logic               rise;
`ifdef CLK_METER_DUTY_EN
   logic               sync2;
   logic [width_p-1:0] hcnt_q, hcnt_d, high_q, high_d;
`endif

   clk_meter_sync u_sync (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .mon_clk_i (mon_clk_i),
`ifdef CLK_METER_DUTY_EN
      .sync2_o   (sync2),
`endif
      .rise_o    (rise)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      to_d      = to_q;
      per_d     = per_q;
      count_d   = count_q;
      stalled_d = stalled_q;
      v_d       = v_q;
`ifdef CLK_METER_DUTY_EN
      hcnt_d    = hcnt_q;
      high_d    = high_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_SYNC;
               to_d    = '0;
            end
         end
         ST_SYNC: begin
            if (rise) begin
               state_d = ST_MEASURE;
               cnt_d   = {{(width_p-1){1'b0}}, 1'b1};
               per_d   = '0;
`ifdef CLK_METER_DUTY_EN
               // The rise cycle itself has sync2=1 and is counted, like cnt.
               hcnt_d  = {{(width_p-1){1'b0}}, 1'b1};
`endif
            end else if (to_q == MAX_C - 1'b1) begin
               state_d   = ST_REPORT;
               count_d   = MAX_C;
               stalled_d = 1'b1;
               v_d       = 1'b1;
`ifdef CLK_METER_DUTY_EN
               high_d    = '0;
`endif
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         ST_MEASURE: begin
            cnt_d = (cnt_q == MAX_C) ? MAX_C : cnt_q + 1'b1;
`ifdef CLK_METER_DUTY_EN
            if (sync2 && hcnt_q != MAX_C) hcnt_d = hcnt_q + 1'b1;
`endif
            // A final rise on the saturation cycle still counts as a clean result.
            if (rise && per_q == LAST_C) begin
               state_d   = ST_REPORT;
               count_d   = cnt_q;
               stalled_d = 1'b0;
               v_d       = 1'b1;
`ifdef CLK_METER_DUTY_EN
               high_d    = hcnt_q;
`endif
            end else if (cnt_q == MAX_C) begin
               state_d   = ST_REPORT;
               count_d   = MAX_C;
               stalled_d = 1'b1;
               v_d       = 1'b1;
`ifdef CLK_METER_DUTY_EN
               high_d    = hcnt_q;
`endif
            end else if (rise) begin
               per_d = per_q + 1'b1;
            end
         end
         ST_REPORT: begin
            if (yumi_i) begin
               state_d = ST_IDLE;
               v_d     = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         to_q      <= '0;
         per_q     <= '0;
         count_q   <= '0;
         stalled_q <= 1'b0;
         v_q       <= 1'b0;
`ifdef CLK_METER_DUTY_EN
         hcnt_q    <= '0;
         high_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         to_q      <= to_d;
         per_q     <= per_d;
         count_q   <= count_d;
         stalled_q <= stalled_d;
         v_q       <= v_d;
`ifdef CLK_METER_DUTY_EN
         hcnt_q    <= hcnt_d;
         high_q    <= high_d;
`endif
      end
   end

   assign count_o   = count_q;
   assign stalled_o = stalled_q;
   assign v_o       = v_q;
`ifdef CLK_METER_DUTY_EN
   assign high_o    = high_q;
`endif

endmodule

// File: doc/clk_meter.md
CLK_METER -- requirements
Module: clk_meter

Interface
REQ-001 Parameter width_p, default 16, meaning width of the cycle counter and of count_o.
REQ-002 Parameter avg_log2_p, default 2, meaning the window spans N = 2**avg_log2_p monitored periods.
REQ-003 Port clk_i, input, 1, the single measurement clock; all logic is on its rising edge.
REQ-004 Port reset_i, input, 1, reset; synchronous, active-high.
REQ-005 Port mon_clk_i, input, 1, clock under test (for example a clock generator output), asynchronous to clk_i.
REQ-006 Port start_i, input, 1, pulse that starts one measurement; honoured only in IDLE.
REQ-007 Port count_o, output, width_p, number of clk_i cycles spanned by N monitored periods.
REQ-008 Port stalled_o, output, 1, set when the result is a timeout rather than a measurement.
REQ-009 Port v_o, output, 1, result valid.
REQ-010 Port yumi_i, input, 1, consumer accepts the result; legal only while v_o=1.

Function
REQ-011 mon_clk_i SHALL pass through a 2-flop synchronizer plus one history flop; a rise pulse is sync2 & ~sync3 (3-cycle latency, 1 cycle wide).
REQ-012 Correct results SHALL be guaranteed only when mon_clk_i high and low phases each last at least 2 clk_i cycles.
REQ-013 FSM states SHALL be IDLE, SYNC, MEASURE and REPORT.
- IDLE -> SYNC on start_i.
- SYNC -> MEASURE on the first rise pulse.
- MEASURE -> REPORT on the Nth subsequent rise pulse.
- REPORT -> IDLE on yumi_i.
REQ-014 On SYNC->MEASURE, cnt SHALL load 1 and the period counter SHALL load 0.
REQ-015 In MEASURE, cnt SHALL increment every cycle; each rise pulse SHALL increment the period counter.
REQ-016 On the Nth rise pulse, count_o SHALL capture cnt, which is the exact cycle distance between the first and the Nth-later rise pulse.
REQ-017 cnt SHALL saturate at 2**width_p-1; reaching saturation in MEASURE SHALL force REPORT with count_o=all-ones and stalled_o=1.
REQ-018 SYNC SHALL run its own timeout counter; if no rise pulse arrives within 2**width_p-1 cycles, it SHALL force REPORT with count_o=all-ones and stalled_o=1.
REQ-019 v_o SHALL be 1 exactly in REPORT.
REQ-020 count_o, stalled_o and v_o SHALL hold stable in REPORT until yumi_i.
REQ-021 start_i outside IDLE SHALL be ignored.
REQ-022 start_i in the same cycle as yumi_i SHALL be ignored; the FSM returns to IDLE first.
REQ-023 A rise pulse coinciding with saturation SHALL take the normal completion path if it is the Nth pulse; otherwise the result is stalled.
REQ-024 count_o and stalled_o SHALL change only on entry to REPORT.

Reset
REQ-025 While reset_i=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-026 While reset_i=1 at a clock edge, the following SHALL clear:
- all counters and sync flops;
- count_o=0, stalled_o=0, v_o=0;
- high_o=0 when present.
REQ-027 Reset asserted mid-MEASURE or mid-REPORT SHALL abandon the measurement with no v_o pulse.
REQ-028 After reset deasserts, the block SHALL remain in IDLE until start_i.

Configuration
REQ-029 Macro CLK_METER_DUTY_EN defined SHALL add output port high_o of width width_p.
- high_o counts MEASURE cycles in which sync2=1.
- high_o is captured with count_o.
- high_o saturates like cnt.
REQ-030 Macro CLK_METER_DUTY_EN undefined SHALL remove the high_o port and its counter; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package clk_meter_pkg SHALL hold the FSM state enum typedef and the state encoding constants.
REQ-032 One sub-module, clk_meter_sync, SHALL hold the synchronizer and the rise-pulse detector.

Verification
REQ-033 mon period 10 cycles, width_p=16, avg_log2_p=2, start_i pulse -> v_o=1, count_o=40, stalled_o=0.
REQ-034 mon_clk_i held low, width_p=8 -> REPORT after 255 SYNC cycles with count_o=255 and stalled_o=1; yumi_i -> IDLE.
REQ-035 Result valid and yumi_i held low 20 cycles -> v_o, count_o and stalled_o stable throughout; start_i pulses in this window have no effect.
REQ-036 reset_i pulsed for 1 cycle mid-MEASURE -> next cycle IDLE, v_o=0, outputs 0; a new start_i then yields a correct count.
REQ-037 CLK_METER_DUTY_EN defined, mon period 10 (3 high, 7 low), N=4 -> count_o=40, high_o=12.
REQ-038 Back-to-back runs: yumi_i, then start_i the next cycle, mon period changed 10 -> 14 -> second count_o=56.
